// File: rtl/median_pkg.sv
// Shared types and helpers for the 3x3 median window sequencer.
package median_pkg;

   localparam int PIX_W = 12;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      RUN,
      EDGE,
      FLUSH
   } state_t;

   // Per-emission metadata carried alongside the pixel pipeline.
   typedef struct packed {
      logic vld;
      logic inner;
      logic sof;
      logic eol;
   } tag_t;

   function automatic int coord_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/Median_Filter.sv
// Combinational RGB444 median of nine taps, taken independently per 4-bit channel.
module Median_Filter (
   input  logic [8:0][11:0] taps,
   output logic [11:0]      median
);

   // The median is the tap with at most four smaller values and at least five not larger.
   function automatic logic [3:0] med9(input logic [35:0] v);
      logic [3:0] lt;
      logic [3:0] le;
      logic [3:0] res;
      res = '0;
      for (int i = 0; i < 9; i++) begin
         lt = '0;
         le = '0;
         for (int j = 0; j < 9; j++) begin
            if (v[j*4 +: 4] <  v[i*4 +: 4]) lt = lt + 4'd1;
            if (v[j*4 +: 4] <= v[i*4 +: 4]) le = le + 4'd1;
         end
         if (lt <= 4'd4 && le >= 4'd5) res = v[i*4 +: 4];
      end
      return res;
   endfunction

   for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      logic [35:0] vals;
      always_comb begin
         vals = '0;
         for (int k = 0; k < 9; k++) vals[k*4 +: 4] = taps[k][ch*4 +: 4];
      end
      assign median[ch*4 +: 4] = med9(vals);
   end

endmodule

// File: rtl/median_line_buffer.sv
// One-line pixel store: single write port, registered single read port.
module median_line_buffer
   import median_pkg::*;
#(
   parameter int DEPTH = 320,
   parameter int AW    = 9
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [PIX_W-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [PIX_W-1:0] rd_data
);

   logic [PIX_W-1:0] mem_q [DEPTH];
   logic [PIX_W-1:0] rd_data_d;
   logic [PIX_W-1:0] rd_data_q;

   // Read returns the contents before a same-cycle write to the same address.
   always_comb rd_data_d = mem_q[rd_addr];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/median_window_ctrl.sv
// Streaming 3x3 window sequencer: two line buffers feed a median filter, one
// output per input pixel, border pixels pass through raw.
module median_window_ctrl
   import median_pkg::*;
#(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_pixel,
   output logic             out_valid,
   output logic [PIX_W-1:0] out_pixel,
   output logic             out_sof,
   output logic             out_eol,
   output logic             busy,
   output logic             overrun
);

   localparam int CW = coord_w(IMG_WIDTH);
   localparam int RW = coord_w(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] COL_INNER = CW'(IMG_WIDTH - 2);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_INNER = RW'(IMG_HEIGHT - 2);

   state_t           state_q, state_d;
   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   logic [RW-1:0]    edge_y_q, edge_y_d;
   logic             overrun_q, overrun_d;

   logic             start, accept, shift, emit, flush_rd, abort;
   logic [CW-1:0]    emit_x, rd_col;
   logic [RW-1:0]    emit_y;

   tag_t             s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
   logic             s1_shift_q, s1_flush_q, s1_acc_q;
   logic [CW-1:0]    s1_col_q;
   logic [PIX_W-1:0] s1_pix_q;

   logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
   logic [PIX_W-1:0] ctr_q, ctr_d;
   logic [PIX_W-1:0] lb0_rd, lb1_rd, mf_median;

   logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eol_q, out_eol_d;
   logic [PIX_W-1:0] out_pixel_q, out_pixel_d;

   assign start = in_valid & in_sof;

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      edge_y_d  = edge_y_q;
      overrun_d = 1'b0;
      accept    = 1'b0;
      shift     = 1'b0;
      emit      = 1'b0;
      flush_rd  = 1'b0;
      abort     = 1'b0;
      emit_x    = '0;
      emit_y    = '0;
      case (state_q)
         IDLE:      accept = start;
         FILL, RUN: accept = in_valid;
         EDGE: begin
            if (start) begin
               accept = 1'b1;
            end else begin
               shift     = 1'b1;
               emit      = 1'b1;
               emit_x    = COL_LAST;
               emit_y    = edge_y_q;
               overrun_d = in_valid;
               // Row wrapped to 0 only after the last line of the frame.
               state_d   = (row_q == '0) ? FLUSH : RUN;
            end
         end
         FLUSH: begin
            if (start) begin
               accept = 1'b1;
            end else begin
               shift     = 1'b1;
               emit      = 1'b1;
               flush_rd  = 1'b1;
               emit_x    = col_q;
               emit_y    = ROW_LAST;
               overrun_d = in_valid;
               if (col_q == COL_LAST) begin
                  col_d   = '0;
                  state_d = IDLE;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         shift = 1'b1;
         if (start) begin
            abort   = (state_q != IDLE);
            state_d = FILL;
            col_d   = CW'(1);
            row_d   = '0;
         end else begin
            if (row_q != '0 && col_q != '0) begin
               emit   = 1'b1;
               emit_x = col_q - CW'(1);
               emit_y = row_q - RW'(1);
            end
            if (col_q == COL_LAST) begin
               col_d    = '0;
               edge_y_d = row_q - RW'(1);
               row_d    = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
               state_d  = (state_q == FILL) ? RUN : EDGE;
            end else begin
               col_d = col_q + CW'(1);
            end
         end
      end
   end

   assign rd_col = (accept && start) ? '0 : col_q;

   always_comb begin
      s1_tag_d.vld   = emit;
      s1_tag_d.inner = (emit_x != '0) && (emit_x <= COL_INNER) &&
                       (emit_y != '0) && (emit_y <= ROW_INNER);
      s1_tag_d.sof   = (emit_x == '0) && (emit_y == '0);
      s1_tag_d.eol   = (emit_x == COL_LAST);

      s2_tag_d     = s1_tag_q;
      s2_tag_d.vld = s1_tag_q.vld & ~abort;

      // Centre normally moves from the newest column into the middle; a flush
      // strobe presents its centre directly from lb0.
      win_d = win_q;
      ctr_d = ctr_q;
      if (s1_shift_q) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb1_rd;
         win_d[1][2] = lb0_rd;
         win_d[2][2] = s1_pix_q;
         ctr_d       = s1_flush_q ? lb0_rd : win_q[1][2];
      end

      out_valid_d = s2_tag_q.vld & ~abort;
      out_sof_d   = out_valid_d & s2_tag_q.sof;
      out_eol_d   = out_valid_d & s2_tag_q.eol;
      out_pixel_d = s2_tag_q.inner ? mf_median : ctr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         edge_y_q    <= '0;
         overrun_q   <= 1'b0;
         s1_tag_q    <= '0;
         s2_tag_q    <= '0;
         s1_shift_q  <= 1'b0;
         s1_acc_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eol_q   <= 1'b0;
         out_pixel_q <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         edge_y_q    <= edge_y_d;
         overrun_q   <= overrun_d;
         s1_tag_q    <= s1_tag_d;
         s2_tag_q    <= s2_tag_d;
         s1_shift_q  <= shift;
         s1_acc_q    <= accept;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_eol_q   <= out_eol_d;
         out_pixel_q <= out_pixel_d;
      end
   end

   always_ff @(posedge clk) begin
      s1_flush_q <= flush_rd;
      s1_col_q   <= rd_col;
      s1_pix_q   <= in_pixel;
      win_q      <= win_d;
      ctr_q      <= ctr_d;
   end

   // lb1 takes the row leaving lb0, written one cycle late once lb0's old data is read out.
   median_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb0 (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (rd_col),
      .wr_data (in_pixel),
      .rd_addr (rd_col),
      .rd_data (lb0_rd)
   );

   median_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
      .clk     (clk),
      .wr_en   (s1_acc_q),
      .wr_addr (s1_col_q),
      .wr_data (lb0_rd),
      .rd_addr (rd_col),
      .rd_data (lb1_rd)
   );

   Median_Filter u_median (
      .taps   (win_q),
      .median (mf_median)
   );

   assign out_valid = out_valid_q;
   assign out_pixel = out_pixel_q;
   assign out_sof   = out_sof_q;
   assign out_eol   = out_eol_q;
   assign busy      = (state_q != IDLE);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_median_window_ctrl.sv
// Randomized frame stimulus for median_window_ctrl checked against a sorted-window reference.
module tb_median_window_ctrl;

   localparam int W = 8;
   localparam int H = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_sof;
   logic [11:0] in_pixel;
   logic        out_valid, out_sof, out_eol, busy, overrun;
   logic [11:0] out_pixel;

   median_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_pixel  (in_pixel),
      .out_valid (out_valid),
      .out_pixel (out_pixel),
      .out_sof   (out_sof),
      .out_eol   (out_eol),
      .busy      (busy),
      .overrun   (overrun)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [13:0] exp_q[$];
   logic [11:0] img [H][W];
   bit          ignore_out = 1'b1;
   int          out_cnt;
   int          sof_cyc;
   int          acc11_cyc;
   logic        samp_ov, samp_or, samp_busy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [3:0] med_ch(int x, int y, int ch);
      int a[9];
      int k;
      int t;
      k = 0;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++) begin
            a[k] = int'(img[y+dy][x+dx][ch*4 +: 4]);
            k++;
         end
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8 - i; j++)
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
      return 4'(a[4]);
   endfunction

   function automatic logic [11:0] ref_pix(int x, int y);
      if (x >= 1 && x <= W-2 && y >= 1 && y <= H-2)
         return {med_ch(x, y, 2), med_ch(x, y, 1), med_ch(x, y, 0)};
      return img[y][x];
   endfunction

   task automatic build_exp();
      exp_q.delete();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            exp_q.push_back({(x == 0 && y == 0), (x == W-1), ref_pix(x, y)});
   endtask

   task automatic make_img(int mode);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            case (mode)
               0:       img[y][x] = 12'hA5C;
               1, 2:    img[y][x] = 12'h000;
               3:       img[y][x] = {4'(x), 4'(y), 4'(x ^ y)};
               default: img[y][x] = 12'($urandom);
            endcase
      if (mode == 1) img[2][3] = 12'hFFF;
      if (mode == 2) img[2][0] = 12'hFFF;
   endtask

   // ---------------- driver ----------------
   task automatic put(input logic v, input logic s, input logic [11:0] p);
      @(negedge clk);
      samp_ov   = out_valid;
      samp_or   = overrun;
      samp_busy = busy;
      in_valid  = v;
      in_sof    = s;
      in_pixel  = p;
   endtask

   task automatic idle(int n);
      repeat (n) put(1'b0, 1'b0, 12'($urandom));
   endtask

   task automatic drive_partial(int stop_y, int stop_x);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (y == stop_y && x == stop_x) return;
            put(1'b1, (x == 0 && y == 0), img[y][x]);
            if (x < W-1) idle($urandom_range(0, 1));
         end
         idle(1);
      end
   endtask

   task automatic send_frame(int line_gap, bit ovr, bit abort_chk);
      out_cnt = 0;
      sof_cyc = -1;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            put(1'b1, (x == 0 && y == 0), img[y][x]);
            if (x == 1 && y == 1) acc11_cyc = cyc;
            if (abort_chk && x == 0 && y == 0) begin
               put(1'b0, 1'b0, 12'h000);
               check("abort_out_valid", samp_ov, 0);
               ignore_out = 1'b0;
            end
            if (x < W-1) idle($urandom_range(0, 1));
         end
         if (ovr && y == 2) begin
            put(1'b1, 1'b0, 12'hBAD);
            put(1'b0, 1'b0, 12'h000);
            check("overrun_edge", samp_or, 1);
            put(1'b0, 1'b0, 12'h000);
            check("overrun_edge_pulse", samp_or, 0);
         end
         if (ovr && y == H-1) begin
            put(1'b0, 1'b0, 12'h000);
            put(1'b1, 1'b0, 12'hBAD);
            put(1'b0, 1'b0, 12'h000);
            check("overrun_flush", samp_or, 1);
            put(1'b0, 1'b0, 12'h000);
            check("overrun_flush_pulse", samp_or, 0);
         end
         idle(line_gap);
      end
      idle(W + 8);
      check("frame_out_count", out_cnt, W*H);
      check("frame_exp_left", exp_q.size(), 0);
      check("busy_after_frame", samp_busy, 0);
      check("first_out_latency", sof_cyc - acc11_cyc, 3);
      exp_q.delete();
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [13:0] e;
      if (!reset && out_valid && !ignore_out) begin
         out_cnt++;
         if (out_sof) sof_cyc = cyc;
         if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("out_pixel", out_pixel, e[11:0]);
            check("out_sof", out_sof, e[13]);
            check("out_eol", out_eol, e[12]);
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_pixel = 12'h000;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_pixel", out_pixel, 0);
      check("rst_out_sof", out_sof, 0);
      check("rst_out_eol", out_eol, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      reset      = 1'b0;
      ignore_out = 1'b0;

      // Stray traffic in IDLE must be ignored silently.
      put(1'b1, 1'b0, 12'h123);
      put(1'b0, 1'b1, 12'h456);
      check("idle_nosof_busy", samp_busy, 0);
      check("idle_nosof_overrun", samp_or, 0);
      put(1'b0, 1'b0, 12'h000);
      check("idle_sofonly_busy", samp_busy, 0);

      make_img(0); build_exp(); send_frame(2, 1'b0, 1'b0);
      make_img(1); build_exp(); send_frame(1, 1'b0, 1'b0);
      make_img(2); build_exp(); send_frame(1, 1'b0, 1'b0);
      make_img(3); build_exp(); send_frame(1, 1'b0, 1'b0);
      make_img(4); build_exp(); send_frame($urandom_range(1, 3), 1'b1, 1'b0);

      // Mid-frame restart at row 3.
      make_img(4);
      ignore_out = 1'b1;
      drive_partial(3, 4);
      make_img(4); build_exp(); send_frame(1, 1'b0, 1'b1);

      // Reset while flushing the last line.
      make_img(4);
      ignore_out = 1'b1;
      drive_partial(H, 0);
      put(1'b0, 1'b0, 12'h000);
      put(1'b0, 1'b0, 12'h000);
      check("busy_in_flush", samp_busy, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("flush_rst_out_valid", out_valid, 0);
      check("flush_rst_out_pixel", out_pixel, 0);
      check("flush_rst_sof_eol", {out_sof, out_eol}, 0);
      check("flush_rst_busy", busy, 0);
      check("flush_rst_overrun", overrun, 0);
      reset = 1'b0;
      idle(4);
      ignore_out = 1'b0;

      make_img(4); build_exp(); send_frame(1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
